// File: rtl/gerenciador_bolas_pkg.sv
// Shared entity constants (coordinate width, screen bounds, ball radius, 60 Hz divider)
// and the helper that locates a slot inside a packed coordinate bus.
package pacote_entidades;

  localparam int W_PADRAO      = 10;
  localparam int LARGURA_TELA  = 640;
  localparam int ALTURA_TELA   = 480;
  localparam int Y_TOPO_TELA   = 0;
  localparam int RAIO_PADRAO   = 5;
  localparam int DIV_TICK_60HZ = 833333;

  // LSB position of slot 'slot' in a bus packing 'largura'-bit fields.
  function automatic int slot_lsb(input int slot, input int largura);
    return slot * largura;
  endfunction

endpackage

// File: rtl/gerenciador_bolas_detector_colisao.sv
// Combinational overlap test between a ball's bounding box and the enemy rectangle,
// evaluated one bit wider than the coordinates so the box edges never wrap.
module detector_colisao
  import pacote_entidades::*;
#(
  parameter int W    = W_PADRAO,
  parameter int RAIO = RAIO_PADRAO
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_ret_x,
  input  logic [W-1:0] i_ret_y,
  input  logic [W-1:0] i_ret_larg,
  input  logic [W-1:0] i_ret_alt,
  output logic         o_colide
);

  localparam int         WE       = W + 1;
  localparam logic [W:0] RAIO_EXT = WE'(RAIO);
  localparam logic [W:0] UM       = WE'(1);

  logic [W:0] w_x, w_y;
  logic [W:0] w_bx_lo, w_bx_hi, w_by_lo, w_by_hi;
  logic [W:0] w_rx_lo, w_rx_hi, w_ry_lo, w_ry_hi;

  assign w_x = {1'b0, i_x};
  assign w_y = {1'b0, i_y};

  // The lower box edges clamp at the screen origin instead of going negative.
  assign w_bx_lo = (w_x >= RAIO_EXT) ? (w_x - RAIO_EXT) : '0;
  assign w_by_lo = (w_y >= RAIO_EXT) ? (w_y - RAIO_EXT) : '0;
  assign w_bx_hi = w_x + RAIO_EXT;
  assign w_by_hi = w_y + RAIO_EXT;

  assign w_rx_lo = {1'b0, i_ret_x};
  assign w_ry_lo = {1'b0, i_ret_y};
  assign w_rx_hi = {1'b0, i_ret_x} + {1'b0, i_ret_larg} - UM;
  assign w_ry_hi = {1'b0, i_ret_y} + {1'b0, i_ret_alt} - UM;

  assign o_colide = (w_bx_lo <= w_rx_hi) && (w_bx_hi >= w_rx_lo) &&
                    (w_by_lo <= w_ry_hi) && (w_by_hi >= w_ry_lo);

endmodule

// File: rtl/gerenciador_bolas.sv
// Pool of allied projectiles: spawns at the ship, climbs each frame tick, retires on exit or hit.
// Optional macro DISPARO_AUTOMATICO_EN turns the fire key into auto-fire while held.
module gerenciador_bolas
  import pacote_entidades::*;
#(
  parameter int N_BOLAS  = 4,
  parameter int W        = W_PADRAO,
  parameter int PASSO    = 4,
  parameter int DIV_TICK = DIV_TICK_60HZ,
  parameter int COOLDOWN = 8,
  parameter int RAIO     = RAIO_PADRAO,
  parameter int Y_TOPO   = Y_TOPO_TELA
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 pausa,
  input  logic                 disparar,
  input  logic [W-1:0]         x_nave,
  input  logic [W-1:0]         y_nave,
  input  logic [W-1:0]         x_inimigo,
  input  logic [W-1:0]         y_inimigo,
  input  logic [W-1:0]         largura_inimigo,
  input  logic [W-1:0]         altura_inimigo,
  output logic [N_BOLAS*W-1:0] x_bolas,
  output logic [N_BOLAS*W-1:0] y_bolas,
  output logic [N_BOLAS-1:0]   ativa,
  output logic [W-1:0]         raio_bola,
  output logic                 acerto,
  output logic [7:0]           n_acertos
);

  localparam int CW  = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int WE  = W + 1;

  localparam logic [CW-1:0]  TICK_MAX  = CW'(DIV_TICK - 1);
  localparam logic [CDW-1:0] CD_CARGA  = CDW'(COOLDOWN);
  localparam logic [W:0]     LIM_SAIDA = WE'(Y_TOPO + PASSO);
  localparam logic [W-1:0]   PASSO_W   = W'(PASSO);

  logic [CW-1:0]  r_cnt;
  logic [CDW-1:0] r_cd;
  logic           r_disp_ant;
  logic [W-1:0]   r_x [N_BOLAS];
  logic [W-1:0]   r_y [N_BOLAS];
  logic [N_BOLAS-1:0] r_ativa;
  logic           r_acerto;
  logic [7:0]     r_n_acertos;

  logic               w_tick, w_fire, w_spawn;
  logic [N_BOLAS-1:0] w_sel, w_colide, w_hit;
  logic [15:0]        w_n_hits, w_total;

  assign w_tick = ~pausa & (r_cnt == TICK_MAX);

`ifdef DISPARO_AUTOMATICO_EN
  assign w_fire = disparar & ~pausa;
`else
  assign w_fire = disparar & ~r_disp_ant & ~pausa;
`endif

  assign w_spawn = w_fire & (r_cd == '0) & ~(&r_ativa);
  assign w_hit   = {N_BOLAS{w_tick}} & r_ativa & w_colide;

  // Lowest-index free slot, taken from the occupancy before this cycle's tick.
  always_comb begin
    logic achou;
    achou = 1'b0;
    w_sel = '0;
    for (int i = 0; i < N_BOLAS; i++) begin
      if (!r_ativa[i] && !achou) begin
        w_sel[i] = 1'b1;
        achou    = 1'b1;
      end
    end
  end

  always_comb begin
    w_n_hits = '0;
    for (int i = 0; i < N_BOLAS; i++) w_n_hits = w_n_hits + 16'(w_hit[i]);
    w_total = 16'(r_n_acertos) + w_n_hits;
  end

  for (genvar g = 0; g < N_BOLAS; g++) begin : g_slot
    detector_colisao #(.W(W), .RAIO(RAIO)) u_detector (
      .i_x       (r_x[g]),
      .i_y       (r_y[g]),
      .i_ret_x   (x_inimigo),
      .i_ret_y   (y_inimigo),
      .i_ret_larg(largura_inimigo),
      .i_ret_alt (altura_inimigo),
      .o_colide  (w_colide[g])
    );
    assign x_bolas[slot_lsb(g, W) +: W] = r_x[g];
    assign y_bolas[slot_lsb(g, W) +: W] = r_y[g];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_cd        <= '0;
      r_disp_ant  <= 1'b0;
      r_ativa     <= '0;
      r_acerto    <= 1'b0;
      r_n_acertos <= '0;
      for (int i = 0; i < N_BOLAS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_disp_ant <= disparar;
      if (!pausa) r_cnt <= (r_cnt == TICK_MAX) ? '0 : r_cnt + CW'(1);
      if (w_spawn) r_cd <= CD_CARGA;
      else if (w_tick && r_cd != '0) r_cd <= r_cd - CDW'(1);
      // A hit retires the ball before the exit test or the move is considered.
      for (int i = 0; i < N_BOLAS; i++) begin
        if (w_spawn && w_sel[i]) begin
          r_x[i]     <= x_nave;
          r_y[i]     <= y_nave;
          r_ativa[i] <= 1'b1;
        end else if (w_tick && r_ativa[i]) begin
          if (w_colide[i]) r_ativa[i] <= 1'b0;
          else if ({1'b0, r_y[i]} < LIM_SAIDA) r_ativa[i] <= 1'b0;
          else r_y[i] <= r_y[i] - PASSO_W;
        end
      end
      r_acerto    <= |w_hit;
      r_n_acertos <= (w_total > 16'd255) ? 8'hFF : w_total[7:0];
    end
  end

  assign ativa     = r_ativa;
  assign acerto    = r_acerto;
  assign n_acertos = r_n_acertos;
  assign raio_bola = W'(RAIO);

endmodule
